// File: rtl/pdm_cic_decimator.sv
// Third-order CIC (sinc^3) decimator turning packed 1-bit PDM words into unsigned PCM samples.
// Bits are integrated serially, one per clock; the comb section runs once per DECIMATION bits.
module pdm_cic_decimator #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned DECIMATION  = 64,
    parameter int unsigned ACC_WIDTH   = 20,
    parameter int unsigned OUT_WIDTH   = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   data_valid_i,
    input  logic [WORD_LENGTH-1:0] data_i,
    output logic                   busy_o,
    output logic [OUT_WIDTH-1:0]   sample_o,
    output logic                   sample_valid_o,
    output logic                   overrun_o
);

    localparam int unsigned BitCntW  = $clog2(WORD_LENGTH);
    localparam int unsigned DecCntW  = $clog2(DECIMATION) + 1;
    localparam int unsigned GainBits = 3 * $clog2(DECIMATION);

    typedef enum logic [1:0] {StIdle, StShift, StComb, StOut} state_e;

    state_e                 r_state;
    logic [WORD_LENGTH-1:0] r_shift;
    logic [BitCntW-1:0]     r_bit_cnt;
    logic [DecCntW-1:0]     r_dec_cnt;
    logic [ACC_WIDTH-1:0]   r_i1, r_i2, r_i3;
    logic [ACC_WIDTH-1:0]   r_d1, r_d2, r_d3;
    logic [ACC_WIDTH-1:0]   r_c3;
    logic [OUT_WIDTH-1:0]   r_sample;
    logic                   r_sample_valid;
    logic                   r_overrun;

    logic                   w_x;
    logic [ACC_WIDTH-1:0]   w_i1, w_i2, w_i3;
    logic [ACC_WIDTH-1:0]   w_c1, w_c2, w_c3;
    logic [GainBits-1:0]    w_sat;
    logic                   w_last_bit;
    logic [DecCntW-1:0]     w_dec_next;

    assign w_x        = r_shift[WORD_LENGTH-1];
    assign w_i1       = r_i1 + {{(ACC_WIDTH-1){1'b0}}, w_x};
    assign w_i2       = r_i2 + w_i1;
    assign w_i3       = r_i3 + w_i2;
    assign w_c1       = r_i3 - r_d1;
    assign w_c2       = w_c1 - r_d2;
    assign w_c3       = w_c2 - r_d3;
    assign w_last_bit = (r_bit_cnt == BitCntW'(WORD_LENGTH - 1));
    assign w_dec_next = r_dec_cnt + 1'b1;

    // Only full-scale input reaches DECIMATION^3; clip it to the largest code.
    assign w_sat = (|r_c3[ACC_WIDTH-1:GainBits]) ? '1 : r_c3[GainBits-1:0];

    always_ff @(posedge clock_i) begin
        if (reset_i || !enable_i) begin
            r_state        <= StIdle;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_dec_cnt      <= '0;
            r_i1           <= '0;
            r_i2           <= '0;
            r_i3           <= '0;
            r_d1           <= '0;
            r_d2           <= '0;
            r_d3           <= '0;
            r_c3           <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            if (reset_i) begin
                r_overrun <= 1'b0;
            end
        end else begin
            r_sample_valid <= 1'b0;
            // A word offered while busy is dropped without touching the datapath.
            if (data_valid_i && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (data_valid_i) begin
                        r_shift   <= data_i;
                        r_bit_cnt <= '0;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    r_shift   <= {r_shift[WORD_LENGTH-2:0], 1'b0};
                    r_i1      <= w_i1;
                    r_i2      <= w_i2;
                    r_i3      <= w_i3;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_dec_cnt <= w_dec_next;
                    if (w_last_bit) begin
                        if (w_dec_next == DecCntW'(DECIMATION)) begin
                            r_dec_cnt <= '0;
                            r_state   <= StComb;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StComb: begin
                    r_d1    <= r_i3;
                    r_d2    <= w_c1;
                    r_d3    <= w_c2;
                    r_c3    <= w_c3;
                    r_state <= StOut;
                end
                StOut: begin
                    r_sample       <= w_sat[GainBits-1 -: OUT_WIDTH];
                    r_sample_valid <= 1'b1;
                    r_state        <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy_o         = (r_state != StIdle);
    assign sample_o       = r_sample;
    assign sample_valid_o = r_sample_valid;
    assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: table of constant PDM streams with hand-computed
// CIC outputs, plus sequences for overrun, enable abort and reset during the output cycle.
module tb_pdm_cic_decimator;

    localparam int GAP = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        dv  = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        busy;
    logic [15:0] samp;
    logic        sv;
    logic        ovr;

    always #5 clk = ~clk;

    pdm_cic_decimator dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .data_valid_i  (dv),
        .data_i        (din),
        .busy_o        (busy),
        .sample_o      (samp),
        .sample_valid_o(sv),
        .overrun_o     (ovr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] samp_q[$];
    int          samp_cyc_q[$];
    int          acc_q[$];
    int          busy_q[$];
    int          busy_run   = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Log every sample pulse and every busy run length.
    always @(negedge clk) begin
        if (sv) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            samp_q.push_back(samp);
            samp_cyc_q.push_back(cyc);
        end
        prev_valid = sv;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            busy_q.push_back(busy_run);
            busy_run = 0;
        end
    end

    task automatic clear_logs();
        samp_q.delete();
        samp_cyc_q.delete();
        acc_q.delete();
        busy_q.delete();
        busy_run = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        dv  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sample", 32'(samp), 32'd0);
        check("reset_valid", 32'(sv), 32'd0);
        check("reset_overrun", 32'(ovr), 32'd0);
        rst = 1'b0;
        clear_logs();
        prev_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the next negedge with the accept edge logged.
    task automatic send_word(input logic [15:0] w);
        dv  = 1'b1;
        din = w;
        @(negedge clk);
        dv = 1'b0;
        acc_q.push_back(cyc);
    endtask

    task automatic send_words(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_word(w);
            repeat (GAP) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          n_words;
        int          exp_count;
        logic [15:0] exp_s[4];
        logic [3:0]  chk;
    } vec_t;

    vec_t vecs[3];

    initial begin
        // All-ones: i3 at 64/128/192 bits = 45760, 357760, 1198144 (mod 2^20 -> 149568);
        // comb outputs 45760, 220480, 262144 -> 0x2CB0, 0xD750, clipped 0xFFFF.
        vecs[0] = '{16'h0000, 12, 3, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'b0111};
        vecs[1] = '{16'hFFFF, 12, 3, '{16'h2CB0, 16'hD750, 16'hFFFF, 16'h0000}, 4'b0111};
        // Alternating bits: H(-1)=0, so settled output is exactly half of 2^18.
        vecs[2] = '{16'hAAAA, 16, 4, '{16'h0000, 16'h0000, 16'h8000, 16'h8000}, 4'b1100};

        for (int v = 0; v < 3; v++) begin
            do_reset();
            send_words(vecs[v].word, vecs[v].n_words);
            check($sformatf("v%0d_sample_count", v), samp_q.size(), vecs[v].exp_count);
            for (int j = 0; j < 4; j++) begin
                if (vecs[v].chk[j] && j < samp_q.size())
                    check($sformatf("v%0d_sample%0d", v, j), 32'(samp_q[j]),
                          32'(vecs[v].exp_s[j]));
            end
            for (int j = 0; j < samp_q.size(); j++) begin
                if (4 * j + 3 < acc_q.size())
                    check($sformatf("v%0d_latency%0d", v, j),
                          samp_cyc_q[j] - acc_q[4 * j + 3], 32'd18);
            end
            check($sformatf("v%0d_busy_runs", v), busy_q.size(), vecs[v].n_words);
            for (int k = 0; k < busy_q.size(); k++)
                check($sformatf("v%0d_busy_len%0d", v, k), busy_q[k], (k % 4 == 3) ? 18 : 16);
            check($sformatf("v%0d_overrun", v), 32'(ovr), 32'd0);
        end

        // Overrun: second strobe 5 cycles after the first is dropped.
        do_reset();
        send_word(16'hAAAA);
        repeat (4) @(negedge clk);
        dv  = 1'b1;
        din = 16'hFFFF;
        @(negedge clk);
        dv = 1'b0;
        check("overrun_set", 32'(ovr), 32'd1);
        repeat (GAP) @(negedge clk);
        send_words(16'hAAAA, 11);
        check("ovr_sample_count", samp_q.size(), 32'd3);
        if (samp_q.size() >= 3) check("ovr_sample2", 32'(samp_q[2]), 32'h8000);
        if (busy_q.size() >= 1) check("ovr_first_busy_len", busy_q[0], 32'd16);
        check("overrun_sticky", 32'(ovr), 32'd1);

        // Enable low mid-SHIFT aborts the word; overrun is kept.
        clear_logs();
        send_word(16'hFFFF);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check("en_abort_busy", 32'(busy), 32'd0);
        check("en_abort_sample", 32'(samp), 32'd0);
        check("en_keeps_overrun", 32'(ovr), 32'd1);
        repeat (GAP) @(negedge clk);
        send_words(16'hFFFF, 12);
        check("en_sample_count", samp_q.size(), 32'd3);
        if (samp_q.size() >= 3) begin
            check("en_sample0", 32'(samp_q[0]), 32'h2CB0);
            check("en_sample1", 32'(samp_q[1]), 32'hD750);
            check("en_sample2", 32'(samp_q[2]), 32'hFFFF);
        end
        check("en_overrun_after", 32'(ovr), 32'd1);

        // Reset landing on the OUT cycle of a boundary word.
        clear_logs();
        send_words(16'hFFFF, 3);
        send_word(16'hFFFF);
        repeat (17) @(negedge clk);
        check("out_state_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(sv), 32'd0);
        check("rst_out_sample", 32'(samp), 32'd0);
        check("rst_out_busy", 32'(busy), 32'd0);
        check("rst_out_overrun", 32'(ovr), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_out_no_sample", samp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
